axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  Synthesizable AXI3 master that executes one read or write transaction per command: single or INCR burst.
//  Accepts a command and streams write data in and read data out.
//  Checks each response's ID and RESP, aborts on a watchdog timeout and reports status.
//  Used by on-chip test engines and as a bench bus driver.
// PARAMETERS
//  AW   32     address width
//  DW   64     data width (32 or 64)
//  IW   4      ID width
//  LW   4      burst length field width (beats = len+1)
//  TMO  1024   watchdog cycles per handshake phase; 0 disables the watchdog
// PORTS
//  aclk_i      in   1       clock
//  arst_i      in   1       synchronous active-high reset
//  cmd_valid_i in   1       command valid
//  cmd_ready_o out  1       command accepted when valid&ready
//  cmd_we_i    in   1       1=write, 0=read
//  cmd_addr_i  in   AW      start address
//  cmd_len_i   in   LW      beats-1
//  cmd_size_i  in   3       bytes per beat = 2**size
//  cmd_id_i    in   IW      transaction ID
//  wd_data_i   in   DW      write data stream; wd_valid_i in 1; wd_ready_o out 1
//  rd_data_o   out  DW      read data stream; rd_valid_o out 1; rd_last_o out 1; no backpressure
//  sts_done_o  out  1       1-cycle pulse at transaction end
//  sts_err_o   out  3       code valid with done: 0 ok, 1 bad ID, 2 SLVERR/DECERR, 3 timeout, 4 illegal cmd
//  AXI aw*/w*/b*/ar*/r* ports as AXI3 master: awid..awlock, wdata/wstrb/wlast, bid/bresp, arid..arlock, rid/rdata/rresp/rlast
// BEHAVIOUR
//  Reset: all valids 0, cmd_ready_o 1, bready_o 0, rready_o 0, sts_* 0.
//    Other AXI outputs reset to 0, except awsize/arsize = log2(DW/8).
//  FSM states: IDLE, ADDR_W, DATA_W, RESP_W, ADDR_R, DATA_R, FIN.
//  IDLE: cmd_ready_o=1. On command accept, latch the command.
//    Go to FIN with err 4 if 2**size > DW/8, or if len>0 with size < log2(DW/8).
//    Otherwise go to ADDR_W (write) or ADDR_R (read).
//  ADDR_W: awvalid and the W channel run concurrently. Either handshake may complete first.
//    AW: awvalid asserted the cycle after accept, held with stable fields until awready.
//    W: beats are forwarded from wd_* combinationally gated: wvalid=wd_valid_i, wd_ready_o=wready_i.
//    wlast=1 on beat len. W is allowed before AW completes.
//  RESP_W: entered when both AW and the last W have completed. bready=1; capture on bvalid.
//    bid != latched id -> err 1; else bresp != 0 -> err 2; else err 0.
//  ADDR_R: arvalid held until arready. Then DATA_R with rready=1.
//    Each r beat is registered to rd_* one cycle later.
//    On rlast, or on the (len+1)th beat, go to FIN.
//    An early rlast, or no rlast on the final beat, flags err 2.
//    ID/RESP errors are sticky over the burst; priority bad ID > resp error.
//  FIN: sts_done_o=1 for one cycle with sts_err_o, then IDLE. cmd_ready_o=0 in every state except IDLE.
//  AXI field values:
//    burst = 2'b01 (INCR) when len>0, else 2'b00.
//    cache=0, prot=0, lock=0.
//    addr = cmd_addr unaligned allowed only for single beat.
//  wstrb:
//    single beat: byte lanes from addr[log2(DW/8)-1:0] and size (byte/half/word/dword masks).
//    bursts: all ones.
//  Watchdog: a counter resets on each phase entry and on every handshake.
//    Reaching TMO: drop all valids/readies, go to FIN with err 3. Outstanding slave beats are not drained.
//  Reset mid-transaction: all outputs return to reset values on the next edge; no done pulse.
//  Throughput: 1 beat/cycle on R and W when the slave is always ready.
//    Minimum single write latency: accept -> done = 4 cycles; single read: accept -> done = 4 cycles.
// TESTING
//  T1 write DW=64 addr=0x40000004 size=2 len=0 data=0x11223344_55667788, slave always ready
//     -> wstrb=8'hF0, done with err 0, awburst=0.
//  T2 read addr=0x40000000 len=7 size=3, slave returns 0..7 with rlast on beat 7
//     -> rd_data 0..7 consecutive, rd_last on 7, done err 0.
//  T3 write len=3 with W presented 3 cycles before awready
//     -> all 4 beats accepted, wlast on beat 3, bid=id, err 0; bresp=2'b10 variant -> err 2.
//  T4 read with rid=id^1 -> err 1.
//     Read with arready held low for TMO=16 cycles -> arvalid drops, done err 3.
//  T5 cmd size=3 len=2 on DW=32 -> no AXI activity, done err 4 two cycles after accept.
//     Assert arst_i mid-burst -> outputs at reset values next cycle, no done pulse.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI3 master-side bus bundle for axi_burst_master: AW/W/B/AR/R channels.
// The master drives the request fields, the slave drives the readies and responses.
interface axi_burst_master_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int IW = 4,
  parameter int LW = 4
);
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [LW-1:0]   awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [1:0]      awlock;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [LW-1:0]   arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [1:0]      arlock;
  logic            arvalid;
  logic            arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// One-command-at-a-time AXI3 master: single or INCR burst read/write with
// response ID/RESP checking, per-phase watchdog and a registered status pulse.
module axi_burst_master #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IW  = 4,
  parameter int LW  = 4,
  parameter int TMO = 1024
) (
  input  logic          aclk_i,
  input  logic          arst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [2:0]    cmd_size_i,
  input  logic [IW-1:0] cmd_id_i,
  input  logic [DW-1:0] wd_data_i,
  input  logic          wd_valid_i,
  output logic          wd_ready_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          rd_last_o,
  output logic          sts_done_o,
  output logic [2:0]    sts_err_o,
  axi_burst_master_if.master axi
);
  localparam int          SB       = DW / 8;
  localparam int          OB       = $clog2(SB);
  localparam logic [2:0]  SZ_FULL  = 3'(OB);
  localparam int          TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  typedef enum logic [2:0] {IDLE, ADDR_W, DATA_W, RESP_W, ADDR_R, DATA_R, FIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d, beat_q, beat_d;
  logic [2:0]    size_q, size_d, err_q, err_d, sts_err_q, sts_err_d;
  logic [IW-1:0] id_q, id_d;
  logic          w_done_q, w_done_d, bad_id_q, bad_id_d, rerr_q, rerr_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          done_q, done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

  logic          w_act, aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_hs, hs, phase;
  logic          r_final, bad_now, rerr_now, illegal;
  logic [SB-1:0] strb;

  assign cmd_ready_o = (state_q == IDLE);
  // W may run while AW is still pending; w_done_q remembers an early last beat
  assign w_act       = (state_q == ADDR_W && !w_done_q) || (state_q == DATA_W);

  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = (len_q != '0) ? 2'b01 : 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awlock  = 2'd0;
  assign axi.awvalid = (state_q == ADDR_W);
  assign axi.wvalid  = w_act & wd_valid_i;
  assign axi.wdata   = w_act ? wd_data_i : '0;
  assign axi.wstrb   = w_act ? strb : '0;
  assign axi.wlast   = w_act && (beat_q == len_q);
  assign axi.bready  = (state_q == RESP_W);
  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = (len_q != '0) ? 2'b01 : 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arlock  = 2'd0;
  assign axi.arvalid = (state_q == ADDR_R);
  assign axi.rready  = (state_q == DATA_R);
  assign wd_ready_o  = w_act & axi.wready;

  assign aw_hs     = axi.awvalid & axi.awready;
  assign w_hs      = axi.wvalid & axi.wready;
  assign w_last_hs = w_hs & (beat_q == len_q);
  assign b_hs      = axi.bready & axi.bvalid;
  assign ar_hs     = axi.arvalid & axi.arready;
  assign r_hs      = axi.rready & axi.rvalid;
  assign hs        = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign phase     = state_q inside {ADDR_W, DATA_W, RESP_W, ADDR_R, DATA_R};
  assign r_final   = (beat_q == len_q);
  assign bad_now   = bad_id_q | (axi.rid != id_q);
  assign rerr_now  = rerr_q | (axi.rresp != 2'b00) | (axi.rlast != r_final);
  assign illegal   = (cmd_size_i > SZ_FULL) || ((cmd_len_i != '0) && (cmd_size_i < SZ_FULL));

  // A byte lane is live when it falls in the same size-aligned block as the start address
  always_comb begin
    strb = '0;
    for (int i = 0; i < SB; i++)
      strb[i] = (len_q != '0) || ((32'(i) >> size_q) == (32'(addr_q[OB-1:0]) >> size_q));
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    id_d      = id_q;
    beat_d    = beat_q;
    w_done_d  = w_done_q;
    bad_id_d  = bad_id_q;
    rerr_d    = rerr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    sts_err_d = 3'd0;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        addr_d   = cmd_addr_i;
        len_d    = cmd_len_i;
        size_d   = cmd_size_i;
        id_d     = cmd_id_i;
        beat_d   = '0;
        w_done_d = 1'b0;
        bad_id_d = 1'b0;
        rerr_d   = 1'b0;
        err_d    = illegal ? 3'd4 : 3'd0;
        state_d  = illegal ? FIN : (cmd_we_i ? ADDR_W : ADDR_R);
      end
      ADDR_W: begin
        if (w_hs) beat_d = beat_q + 1'b1;
        if (w_last_hs) w_done_d = 1'b1;
        if (aw_hs) state_d = (w_done_q || w_last_hs) ? RESP_W : DATA_W;
      end
      DATA_W: begin
        if (w_hs) beat_d = beat_q + 1'b1;
        if (w_last_hs) state_d = RESP_W;
      end
      RESP_W: if (b_hs) begin
        err_d   = (axi.bid != id_q) ? 3'd1 : (axi.bresp != 2'b00) ? 3'd2 : 3'd0;
        state_d = FIN;
      end
      ADDR_R: if (ar_hs) state_d = DATA_R;
      DATA_R: if (r_hs) begin
        rd_valid_d = 1'b1;
        rd_data_d  = axi.rdata;
        beat_d     = beat_q + 1'b1;
        bad_id_d   = bad_now;
        rerr_d     = rerr_now;
        if (axi.rlast || r_final) begin
          rd_last_d = 1'b1;
          err_d     = bad_now ? 3'd1 : rerr_now ? 3'd2 : 3'd0;
          state_d   = FIN;
        end
      end
      FIN: begin
        done_d    = 1'b1;
        sts_err_d = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stalled phase: abandon the transaction; any beats still owed by the slave are ignored
    if (TMO != 0 && phase && !hs && wd_q == TMO_LAST) begin
      state_d = FIN;
      err_d   = 3'd3;
    end
    wd_d = (!phase || hs || state_d != state_q) ? '0 : wd_q + 1'b1;
  end

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= SZ_FULL;
      id_q       <= '0;
      beat_q     <= '0;
      w_done_q   <= 1'b0;
      bad_id_q   <= 1'b0;
      rerr_q     <= 1'b0;
      err_q      <= 3'd0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      sts_err_q  <= 3'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      id_q       <= id_d;
      beat_q     <= beat_d;
      w_done_q   <= w_done_d;
      bad_id_q   <= bad_id_d;
      rerr_q     <= rerr_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      sts_err_q  <= sts_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign sts_done_o = done_q;
  assign sts_err_o  = sts_err_q;
endmodule
